// File: rtl/arm_mc_pkg.sv
// Shared encodings for the ARM-subset multicycle controller: FSM states, datapath
// select codes, Op/cmd constants and the condition-code evaluator.
package arm_mc_pkg;

   typedef enum logic [3:0] {
      StFetch,
      StDecode,
      StMemAdr,
      StMemRead,
      StMemWb,
      StMemWrite,
      StExecuteR,
      StExecuteI,
      StAluWb,
      StBranch
   } state_e;

   localparam logic [1:0] AluAdd = 2'b00;
   localparam logic [1:0] AluSub = 2'b01;
   localparam logic [1:0] AluAnd = 2'b10;
   localparam logic [1:0] AluOrr = 2'b11;

   localparam logic [1:0] SrcAReg    = 2'b00;
   localparam logic [1:0] SrcAPc     = 2'b01;
   localparam logic [1:0] SrcAAluOut = 2'b10;

   localparam logic [1:0] SrcBWd   = 2'b00;
   localparam logic [1:0] SrcBImm  = 2'b01;
   localparam logic [1:0] SrcBFour = 2'b10;

   localparam logic [1:0] ResAluOut    = 2'b00;
   localparam logic [1:0] ResData      = 2'b01;
   localparam logic [1:0] ResAluResult = 2'b10;

   localparam logic [1:0] OpDp     = 2'b00;
   localparam logic [1:0] OpMem    = 2'b01;
   localparam logic [1:0] OpBranch = 2'b10;

   localparam logic [3:0] CmdAnd = 4'b0000;
   localparam logic [3:0] CmdSub = 4'b0010;
   localparam logic [3:0] CmdAdd = 4'b0100;
   localparam logic [3:0] CmdCmp = 4'b1010;
   localparam logic [3:0] CmdOrr = 4'b1100;

   // flags = {N, Z, C, V}; cond 1111 is treated as never.
   function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
      logic n, z, c, v;
      logic res;
      {n, z, c, v} = flags;
      case (cond)
         4'b0000: res = z;
         4'b0001: res = ~z;
         4'b0010: res = c;
         4'b0011: res = ~c;
         4'b0100: res = n;
         4'b0101: res = ~n;
         4'b0110: res = v;
         4'b0111: res = ~v;
         4'b1000: res = c & ~z;
         4'b1001: res = ~c | z;
         4'b1010: res = (n == v);
         4'b1011: res = (n != v);
         4'b1100: res = ~z & (n == v);
         4'b1101: res = z | (n != v);
         4'b1110: res = 1'b1;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/cond_logic.sv
// NZCV flags register plus condition evaluation; the result is latched into cond_ex_q
// during DECODE and qualifies every write of the instruction that follows.
module cond_logic
   import arm_mc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cond,
   input  logic [3:0] alu_flags,
   input  logic [1:0] flag_w,
   input  logic       cond_latch,
   output logic       cond_ex_q
);

   logic [3:0] flags_q, flags_d;
   logic       cond_ex_d;

   always_comb begin
      flags_d   = flags_q;
      cond_ex_d = cond_ex_q;
      if (flag_w[1] && cond_ex_q) flags_d[3:2] = alu_flags[3:2];
      if (flag_w[0] && cond_ex_q) flags_d[1:0] = alu_flags[1:0];
      if (cond_latch) cond_ex_d = cond_eval(cond, flags_q);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flags_q   <= 4'b0000;
         cond_ex_q <= 1'b0;
      end else begin
         flags_q   <= flags_d;
         cond_ex_q <= cond_ex_d;
      end
   end

endmodule

// File: rtl/mc_controller.sv
// Multicycle sequencing controller: instruction decode, per-instruction FSM and
// write-enable gating. Define MEM_READY_EN to add MemReady wait states on memory cycles.
module mc_controller
   import arm_mc_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instr,
   input  logic [3:0]  ALUFlags,
`ifdef MEM_READY_EN
   input  logic        MemReady,
`endif
   output logic        PCWrite,
   output logic        MemWrite,
   output logic        RegWrite,
   output logic        IRWrite,
   output logic        AdrSrc,
   output logic [1:0]  RegSrc,
   output logic [1:0]  ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ResultSrc,
   output logic [1:0]  ImmSrc,
   output logic [1:0]  ALUControl
);

   state_e     state_q, state_d;
   logic [1:0] op;
   logic       i_bit, s_bit;
   logic [3:0] cmd, rd, cond;
   logic       ready;
   logic       unused_instr;

   logic [1:0] dp_ctrl, dp_flag_w;
   logic       no_write;

   logic       next_pc, branch, reg_w, mem_w, ir_write, cond_latch, cond_ex_q;
   logic [1:0] flag_w;

   assign op           = Instr[27:26];
   assign i_bit        = Instr[25];
   assign cmd          = Instr[24:21];
   assign s_bit        = Instr[20];
   assign rd           = Instr[15:12];
   assign cond         = Instr[31:28];
   assign unused_instr = ^Instr[11:0];

`ifdef MEM_READY_EN
   assign ready = MemReady;
`else
   assign ready = 1'b1;
`endif

   assign RegSrc = {op == OpMem, op == OpBranch};
   assign ImmSrc = op;

   always_comb begin
      dp_ctrl   = AluAdd;
      dp_flag_w = 2'b00;
      no_write  = 1'b1;
      case (cmd)
         CmdAdd: begin
            dp_ctrl   = AluAdd;
            no_write  = 1'b0;
            dp_flag_w = {s_bit, s_bit};
         end
         CmdSub: begin
            dp_ctrl   = AluSub;
            no_write  = 1'b0;
            dp_flag_w = {s_bit, s_bit};
         end
         CmdAnd: begin
            dp_ctrl   = AluAnd;
            no_write  = 1'b0;
            dp_flag_w = {s_bit, 1'b0};
         end
         CmdOrr: begin
            dp_ctrl   = AluOrr;
            no_write  = 1'b0;
            dp_flag_w = {s_bit, 1'b0};
         end
         CmdCmp: begin
            dp_ctrl   = AluSub;
            dp_flag_w = 2'b11;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      next_pc    = 1'b0;
      branch     = 1'b0;
      reg_w      = 1'b0;
      mem_w      = 1'b0;
      ir_write   = 1'b0;
      cond_latch = 1'b0;
      flag_w     = 2'b00;
      AdrSrc     = 1'b0;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ResultSrc  = 2'b00;
      ALUControl = AluAdd;
      case (state_q)
         StFetch: begin
            ALUSrcA   = SrcAPc;
            ALUSrcB   = SrcBFour;
            ResultSrc = ResAluResult;
            ir_write  = ready;
            next_pc   = ready;
            if (ready) state_d = StDecode;
         end
         StDecode: begin
            ALUSrcA    = SrcAPc;
            ALUSrcB    = SrcBFour;
            ResultSrc  = ResAluResult;
            cond_latch = 1'b1;
            case (op)
               OpDp:     state_d = i_bit ? StExecuteI : StExecuteR;
               OpMem:    state_d = StMemAdr;
               OpBranch: state_d = StBranch;
               default:  state_d = StFetch;
            endcase
         end
         StExecuteR, StExecuteI: begin
            ALUSrcA    = SrcAReg;
            ALUSrcB    = (state_q == StExecuteI) ? SrcBImm : SrcBWd;
            ALUControl = dp_ctrl;
            flag_w     = dp_flag_w;
            state_d    = (cmd == CmdCmp) ? StFetch : StAluWb;
         end
         StAluWb: begin
            ResultSrc = ResAluOut;
            reg_w     = ~no_write;
            state_d   = StFetch;
         end
         StMemAdr: begin
            ALUSrcA = SrcAReg;
            ALUSrcB = SrcBImm;
            state_d = s_bit ? StMemRead : StMemWrite;
         end
         StMemRead: begin
            AdrSrc    = 1'b1;
            ResultSrc = ResAluOut;
            if (ready) state_d = StMemWb;
         end
         StMemWb: begin
            ResultSrc = ResData;
            reg_w     = 1'b1;
            state_d   = StFetch;
         end
         StMemWrite: begin
            AdrSrc    = 1'b1;
            ResultSrc = ResAluOut;
            mem_w     = 1'b1;
            if (ready) state_d = StFetch;
         end
         StBranch: begin
            ALUSrcA   = SrcAAluOut;
            ALUSrcB   = SrcBImm;
            ResultSrc = ResAluResult;
            branch    = 1'b1;
            state_d   = StFetch;
         end
         default: state_d = StFetch;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= StFetch;
      else        state_q <= state_d;
   end

   cond_logic u_cond_logic (
      .clk        (clk),
      .reset      (reset),
      .cond       (cond),
      .alu_flags  (ALUFlags),
      .flag_w     (flag_w),
      .cond_latch (cond_latch),
      .cond_ex_q  (cond_ex_q)
   );

   // Enables are masked combinationally while reset is held so nothing is written.
   assign IRWrite  = reset & ir_write;
   assign RegWrite = reset & reg_w & cond_ex_q;
   assign MemWrite = reset & mem_w & cond_ex_q;
   assign PCWrite  = reset & (next_pc | ((branch | (reg_w & (rd == 4'hF))) & cond_ex_q));

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: each cycle's expected control vector is queued and
// then popped against the DUT outputs mid-cycle.
module tb_mc_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Instr;
   logic [3:0]  ALUFlags;
   logic        MemReady;
   logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
   logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

   int checks   = 0;
   int failures = 0;
   logic [16:0] sb[$];

   always #5 clk = ~clk;

   mc_controller dut (
      .clk        (clk),
      .reset      (reset),
      .Instr      (Instr),
      .ALUFlags   (ALUFlags),
`ifdef MEM_READY_EN
      .MemReady   (MemReady),
`endif
      .PCWrite    (PCWrite),
      .MemWrite   (MemWrite),
      .RegWrite   (RegWrite),
      .IRWrite    (IRWrite),
      .AdrSrc     (AdrSrc),
      .RegSrc     (RegSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ResultSrc  (ResultSrc),
      .ImmSrc     (ImmSrc),
      .ALUControl (ALUControl)
   );

   logic [16:0] obs;
   assign obs = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB,
                 ResultSrc, ImmSrc, ALUControl};

   // RegSrc and ImmSrc come straight from the instruction's Op field.
   function automatic logic [16:0] ev(input logic pcw, input logic mw, input logic rw,
                                      input logic irw, input logic adr, input logic [1:0] a,
                                      input logic [1:0] b, input logic [1:0] res,
                                      input logic [1:0] alu);
      logic [1:0] opf;
      opf = Instr[27:26];
      return {pcw, mw, rw, irw, adr, opf == 2'b01, opf == 2'b10, a, b, res, opf, alu};
   endfunction

   function automatic logic [16:0] v_fetch();
      return ev(1, 0, 0, 1, 0, 2'b01, 2'b10, 2'b10, 2'b00);
   endfunction
   function automatic logic [16:0] v_idle_fetch();
      return ev(0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 2'b00);
   endfunction
   function automatic logic [16:0] v_memadr();
      return ev(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00);
   endfunction
   function automatic logic [16:0] v_branch(input logic taken);
      return ev(taken, 0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b00);
   endfunction

   task automatic check(input string tag, input logic [16:0] expv);
      logic [16:0] e;
      sb.push_back(expv);
      #1;
      e = sb.pop_front();
      checks++;
      assert (obs === e) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
   endtask

   task automatic step(input string tag, input logic [16:0] expv);
      check(tag, expv);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset    = 1'b0;
      Instr    = 32'hE0821003;
      ALUFlags = 4'b0000;
      MemReady = 1'b1;
      @(negedge clk);
      check("reset_state", v_idle_fetch());
      reset = 1'b1;

      // ADD R1,R2,R3
      step("add_fetch", v_fetch());
      step("add_decode", v_idle_fetch());
      step("add_execr", ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
      step("add_aluwb", ev(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));

      // LDR R1,[R2,#4]
      Instr = 32'hE5921004;
      step("ldr_fetch", v_fetch());
      step("ldr_decode", v_idle_fetch());
      step("ldr_memadr", v_memadr());
      step("ldr_memread", ev(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00));
      step("ldr_memwb", ev(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00));

      // STR
      Instr = 32'hE5821004;
      step("str_fetch", v_fetch());
      step("str_decode", v_idle_fetch());
      step("str_memadr", v_memadr());
      step("str_memwrite", ev(0, 1, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00));

      // SUBS R0,R0,#1 producing Z
      Instr = 32'hE2500001;
      step("subs_fetch", v_fetch());
      step("subs_decode", v_idle_fetch());
      ALUFlags = 4'b0100;
      step("subs_execi", ev(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b01));
      ALUFlags = 4'b0000;
      step("subs_aluwb", ev(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));

      Instr = 32'h0A000002;
      step("beq_fetch", v_fetch());
      step("beq_decode", v_idle_fetch());
      step("beq_taken", v_branch(1'b1));

      Instr = 32'h1A000002;
      step("bne_fetch", v_fetch());
      step("bne_decode", v_idle_fetch());
      step("bne_not_taken", v_branch(1'b0));

      // ADDNE with Z set: no register write
      Instr = 32'h10821003;
      step("addne_fetch", v_fetch());
      step("addne_decode", v_idle_fetch());
      step("addne_execr", ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
      step("addne_aluwb", ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));

      Instr = 32'hEC000000;
      step("undef_fetch", v_fetch());
      step("undef_decode", v_idle_fetch());

      // Reset asserted mid-LDR
      Instr = 32'hE5921004;
      step("ldr2_fetch", v_fetch());
      step("ldr2_decode", v_idle_fetch());
      step("ldr2_memadr", v_memadr());
      check("ldr2_memread", ev(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00));
      reset = 1'b0;
      check("reset_mid_memread", v_idle_fetch());
      @(negedge clk);
      Instr = 32'h0A000002;
      check("reset_held", v_idle_fetch());
      reset = 1'b1;
      step("post_reset_fetch", v_fetch());
      step("post_reset_decode", v_idle_fetch());
      step("beq_flags_cleared", v_branch(1'b0));

      // CMP R0,#0 sets Z; three cycles then BEQ taken
      Instr = 32'hE3500000;
      step("cmp_fetch", v_fetch());
      step("cmp_decode", v_idle_fetch());
      ALUFlags = 4'b0100;
      step("cmp_execi", ev(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b01));
      ALUFlags = 4'b0000;
      Instr = 32'h0A000002;
      step("beq2_fetch", v_fetch());
      step("beq2_decode", v_idle_fetch());
      step("beq2_taken", v_branch(1'b1));

`ifdef MEM_READY_EN
      Instr    = 32'hE0821003;
      MemReady = 1'b0;
      step("wait_fetch0", v_idle_fetch());
      step("wait_fetch1", v_idle_fetch());
      step("wait_fetch2", v_idle_fetch());
      MemReady = 1'b1;
      step("ready_fetch", v_fetch());
      step("ready_decode", v_idle_fetch());
      step("ready_execr", ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
      step("ready_aluwb", ev(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
`endif

      Instr = 32'hEC000000;
      step("final_fetch", v_fetch());

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
